// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue between a bus-side write port and a UART sender.
// Bytes are held in a circular buffer and drained one at a time through a
// three-state handshake on tx_en / tx_status.
// Optional feature macro: UART_TXQ_OVERFLOW_FLAG_EN adds a sticky overflow
// output that records any write dropped because the queue was full.
module uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    tx_data,
  output logic          tx_en,
  input  logic          tx_status
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
  ,
  output logic          overflow
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_IDLE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;

  // A write is accepted only when the queue was not full before this edge,
  // so a pop on the same edge cannot make room for it.
  assign push = wr_en & ~full;

  // Next-state logic for the drain handshake; pop fires on leaving IDLE.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_status) begin
          state_next = LAUNCH;
          pop        = 1'b1;
        end
      end
      LAUNCH: begin
        if (!tx_status) state_next = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (tx_status) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
    end
  end

  // UART-side outputs: tx_data captures the head byte on pop and holds it,
  // tx_en mirrors residence in LAUNCH one register stage after the decision.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_data <= 8'h00;
      tx_en   <= 1'b0;
    end else begin
      if (pop) tx_data <= mem[rd_ptr];
      tx_en <= (state_next == LAUNCH);
    end
  end

`ifdef UART_TXQ_OVERFLOW_FLAG_EN
  // Sticky record of any write that arrived while the queue was full.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)            overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench for uart_tx_queue with a queue-based
// reference model compared on every falling clock edge.
module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          sysclk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_status;
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  int vectors    = 0;
  int miscompares = 0;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_status (tx_status)
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  // 10-unit clock period
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Reference model: a FIFO of pending bytes plus the sender handshake
  // described as "ready / requesting / waiting for idle".
  logic [7:0] mq [$];
  int         m_phase;
  logic [7:0] m_txd;
  bit         m_ovf;
  bit         m_was_full;
  bit         m_pop;

  always @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_phase = 0;
      m_txd   = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      m_was_full = (mq.size() == DEPTH);
      m_pop      = (m_phase == 0) && (mq.size() != 0) && tx_status;
      if (m_pop) begin
        m_txd   = mq.pop_front();
        m_phase = 1;
      end else if (m_phase == 1 && !tx_status) begin
        m_phase = 2;
      end else if (m_phase == 2 && tx_status) begin
        m_phase = 0;
      end
      if (wr_en) begin
        if (m_was_full) m_ovf = 1'b1;
        else            mq.push_back(wr_data);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model while out of reset.
  always @(negedge sysclk) begin
    if (reset) begin
      checkOutput("cmp_count", 32'(count), 32'(mq.size()));
      checkOutput("cmp_empty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("cmp_full",  32'(full),  32'(mq.size() == DEPTH));
      checkOutput("cmp_tx_en", 32'(tx_en), 32'(m_phase == 1));
      checkOutput("cmp_tx_data", 32'(tx_data), 32'(m_txd));
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
      checkOutput("cmp_overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
  end

  // Drive inputs just after a falling edge and advance one full cycle.
  task automatic applyStimulus(input logic we, input logic [7:0] d,
                               input logic ts);
    wr_en     = we;
    wr_data   = d;
    tx_status = ts;
    @(negedge sysclk);
  endtask

  // One complete send of the head byte starting from the ready state.
  task automatic drainOne(input logic [7:0] exp);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_tx_en", 32'(tx_en), 32'd1);
    checkOutput("drain_tx_data", 32'(tx_data), 32'(exp));
    checkOutput("model_tx_data", 32'(m_txd), 32'(exp));
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    tx_status = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full",  32'(full),  32'd0);
    checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    reset = 1'b1;

    // Single byte, first-transaction latency
    applyStimulus(1'b1, 8'h41, 1'b1);
    checkOutput("one_count", 32'(count), 32'd1);
    checkOutput("one_tx_en_pre", 32'(tx_en), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("one_tx_en", 32'(tx_en), 32'd1);
    checkOutput("one_tx_data", 32'(tx_data), 32'h41);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("one_tx_en_drop", 32'(tx_en), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("one_empty", 32'(empty), 32'd1);

    // Fill to full while the sender is busy, then overfill
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("fill_full",  32'(full),  32'd1);
    checkOutput("fill_count", 32'(count), 32'd8);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("drop_count", 32'(count), 32'd8);
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    checkOutput("drop_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 8; i++) drainOne(8'(i));
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Write on the pop edge while full is dropped
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("popfull_count", 32'(count), 32'd7);
    checkOutput("popfull_tx_data", 32'(tx_data), 32'h10);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 1; i < 5; i++) drainOne(8'(8'h10 + i));
    checkOutput("three_count", 32'(count), 32'd3);
    // Simultaneous push and pop
    applyStimulus(1'b1, 8'h99, 1'b1);
    checkOutput("pushpop_count", 32'(count), 32'd3);
    checkOutput("pushpop_tx_data", 32'(tx_data), 32'h15);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    drainOne(8'h16);
    drainOne(8'h17);
    drainOne(8'h99);
    checkOutput("pushpop_empty", 32'(empty), 32'd1);

    // 20 bytes in batches of four; pointers wrap repeatedly
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'h80 + b*4 + k), 1'b0);
      checkOutput("wrap_batch_count", 32'(count), 32'd4);
      for (int k = 0; k < 4; k++) drainOne(8'(8'h80 + b*4 + k));
    end
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset while launching with four bytes still queued
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("arst_pre_count", 32'(count), 32'd4);
    checkOutput("arst_pre_tx_en", 32'(tx_en), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_tx_en",  32'(tx_en), 32'd0);
    checkOutput("arst_count",  32'(count), 32'd0);
    checkOutput("arst_empty",  32'(empty), 32'd1);
    checkOutput("arst_tx_data", 32'(tx_data), 32'h00);
    @(negedge sysclk);
    reset = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_tx_en", 32'(tx_en), 32'd1);
    checkOutput("post_rst_tx_data", 32'(tx_data), 32'h5A);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue depth in bytes; SHALL be a power of two, 2..64.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 sysclk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  one-cycle write strobe from the bus side.
REQ-006 wr_data  input  8  byte to enqueue, sampled when wr_en=1.
REQ-007 full  output  1  queue holds DEPTH bytes.
REQ-008 empty  output  1  queue holds 0 bytes.
REQ-009 count  output  AW+1  bytes currently queued, 0..DEPTH.
REQ-010 tx_data  output  8  byte presented to the UART transmit data input (UART_TXD).
REQ-011 tx_en  output  1  send request to the UART (TX_EN).
REQ-012 tx_status  input  1  UART sender flag (TX_STATUS); 1 = sender idle, 0 = sending.
REQ-013 overflow  output  1  sticky dropped-write flag; present only under REQ-030.

Function
REQ-014 Storage SHALL be a circular buffer with AW-bit read/write pointers wrapping DEPTH-1 -> 0, and a separate AW+1-bit count.
REQ-015 Write: on an edge with wr_en=1 and full=0, wr_data SHALL be stored at the write pointer, the pointer SHALL advance, and count SHALL increment.
REQ-016 A write with full=1 at that edge SHALL be dropped with no state change, even if a pop occurs on the same edge.
REQ-017 full, empty and count SHALL be registered and reflect state after the current edge; full=(count==DEPTH), empty=(count==0).
REQ-018 Drain FSM states: IDLE, LAUNCH, WAIT_IDLE.
REQ-019 IDLE -> LAUNCH when empty=0 and tx_status=1; on that edge the head byte SHALL be registered into tx_data, the read pointer SHALL advance, and count SHALL decrement (pop).
REQ-020 A push and a pop on the same edge SHALL leave count unchanged and SHALL both take effect.
REQ-021 LAUNCH: tx_en=1; remain until tx_status=0 is sampled, then go to WAIT_IDLE.
REQ-022 WAIT_IDLE: tx_en=0; on tx_status=1 return to IDLE.
REQ-023 tx_en SHALL be a registered output, high exactly while in LAUNCH.
REQ-024 tx_data SHALL hold its value from the pop until the next pop.
REQ-025 Latency: a byte written into an empty queue at edge N with tx_status=1 SHALL produce tx_en=1 and valid tx_data from edge N+1.
REQ-026 Bytes SHALL be transmitted in write order, with no loss or duplication except drops under REQ-016.

Reset
REQ-027 reset=0 SHALL immediately force: pointers=0, count=0, empty=1, full=0, FSM=IDLE, tx_en=0, tx_data=8'h00, overflow=0.
REQ-028 Reset during LAUNCH or WAIT_IDLE SHALL discard all queued bytes; the in-flight byte is not retried.
REQ-029 Storage array contents SHALL NOT require reset.

Configuration
REQ-030 Macro UART_TXQ_OVERFLOW_FLAG_EN:
- Defined: overflow port exists; overflow SHALL set on any write dropped per REQ-016 and clear only on reset.
- Undefined: the port and its logic are absent; dropped writes are silent.

Verification
REQ-031 After reset release, write 8'h41 with tx_status=1 -> next edge tx_en=1 and tx_data=8'h41; tx_status drops to 0 -> tx_en=0; tx_status returns to 1 -> FSM in IDLE, empty=1.
REQ-032 Hold tx_status=0 and write 8'h00..8'h07 (DEPTH=8) -> full=1, count=8; write 8'hFF -> dropped, overflow=1 when the macro is defined; then toggle tx_status per byte -> tx_data sequence 00..07, never FF.
REQ-033 With count=8 and tx_status=1, issue a write on the pop edge -> write dropped and count=7; with count=3, push and pop on the same edge -> count stays 3.
REQ-034 Push and drain 20 bytes through DEPTH=8 -> pointers wrap twice, output order matches input order, empty=1 at end.
REQ-035 Assert reset=0 while in LAUNCH with 4 bytes queued -> tx_en=0, count=0 and empty=1 without a clock edge; after release a new write of 8'h5A is sent first.
